// File: rtl/serial_sub_pkg.sv
// Shared FSM encoding and counter sizing for the bit-serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One spare bit above clog2 so the count never wraps inside an operation.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Request/result bundle between a requester and the bit-serial subtractor.
interface serial_sub_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_sub_full_sub.sv
// Single-bit full subtractor used by the serial datapath.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: one bit per clock, LSB first, result registered on completion.
// state | meaning
// IDLE  | waiting for start
// RUN   | shifting one bit per cycle through the full subtractor
// DONE  | result just loaded, done pulse; start here chains the next operation
module serial_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    serial_sub_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic             load, step, finish;
    logic [WIDTH-1:0] a_sh, b_sh, part;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             bit_d, bit_b;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q, busy_q, done_q;

    full_sub u_fs (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .bin (br),
        .diff(bit_d),
        .bout(bit_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            part   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_next == RUN);
            done_q <= (state_next == DONE);
            if (load) begin
                a_sh <= bus.a;
                b_sh <= bus.b;
                br   <= bus.bin;
                part <= '0;
                cnt  <= '0;
            end else if (step) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                br   <= bit_b;
                part <= {bit_d, part[WIDTH-1:1]};
                cnt  <= cnt + 1'b1;
            end
            // Final bit goes straight into the result so diff lands on the RUN->DONE edge.
            if (finish) begin
                diff_q <= {bit_d, part[WIDTH-1:1]};
                bout_q <= bit_b;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub at WIDTH=8 and WIDTH=13 against an arithmetic reference.
module tb_serial_sub;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_sub_if #(.WIDTH(8))  bus8 ();
    serial_sub_if #(.WIDTH(13)) bus13 ();

    serial_sub #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    serial_sub #(.WIDTH(13)) dut13 (.clk(clk), .rst(rst), .bus(bus13));

    function automatic longint ref_diff(input longint a, input longint b, input longint bin, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (a - b - bin) & m;
    endfunction

    function automatic bit ref_bout(input longint a, input longint b, input longint bin);
        return (a < b + bin);
    endfunction

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.bin = bin;
        @(posedge clk);
        #1 bus8.start = 1'b0;
    endtask

    task automatic wait_done8(output int busy_cycles, output bit ok);
        busy_cycles = 0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus8.done) begin ok = 1'b1; break; end
            if (bus8.busy) busy_cycles++;
        end
    endtask

    task automatic start13(input logic [12:0] a, input logic [12:0] b, input logic bin);
        @(negedge clk);
        bus13.start = 1'b1; bus13.a = a; bus13.b = b; bus13.bin = bin;
        @(posedge clk);
        #1 bus13.start = 1'b0;
    endtask

    task automatic wait_done13(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus13.done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.bin = 1'b0;
        bus13.start = 1'b0; bus13.a = '0; bus13.b = '0; bus13.bin = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus8.busy, bus8.done, bus8.diff, bus8.bout} !== 11'd0) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b diff=%h bout=%b, required all 0",
                     bus8.busy, bus8.done, bus8.diff, bus8.bout);
        end
        checks++;
        if ({bus13.busy, bus13.done, bus13.diff, bus13.bout} !== 16'd0) begin
            errors++;
            $display("FAIL reset13: busy=%b done=%b diff=%h bout=%b, required all 0",
                     bus13.busy, bus13.done, bus13.diff, bus13.bout);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] va [3] = '{8'h05, 8'h03, 8'h00};
        logic [7:0] vb [3] = '{8'h03, 8'h05, 8'h00};
        logic       vc [3] = '{1'b0, 1'b0, 1'b1};
        int  bc;
        bit  ok;
        logic [7:0] ed;
        logic       eb;
        for (int i = 0; i < 3; i++) begin
            ed = 8'(ref_diff(longint'(va[i]), longint'(vb[i]), longint'(vc[i]), 8));
            eb = ref_bout(longint'(va[i]), longint'(vb[i]), longint'(vc[i]));
            start8(va[i], vb[i], vc[i]);
            wait_done8(bc, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL basic_done[%0d]: no done within bound, required done", i); end
            checks++;
            if (bc != 8) begin errors++; $display("FAIL basic_busy[%0d]: busy cycles %0d, required 8", i, bc); end
            checks++;
            if (bus8.diff !== ed || bus8.bout !== eb) begin
                errors++;
                $display("FAIL basic_result[%0d]: diff=%h bout=%b, required diff=%h bout=%b", i, bus8.diff, bus8.bout, ed, eb);
            end
            @(negedge clk);
            checks++;
            if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
                errors++;
                $display("FAIL basic_pulse[%0d]: done=%b busy=%b after pulse, required 0 0", i, bus8.done, bus8.busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bc;
        bit ok;
        start8(8'hFF, 8'h00, 1'b0);
        wait_done8(bc, ok);
        checks++;
        if (!ok || bus8.diff !== 8'hFF || bus8.bout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: ok=%b diff=%h bout=%b, required 1 ff 0", ok, bus8.diff, bus8.bout);
        end
        bus8.start = 1'b1; bus8.a = 8'h80; bus8.b = 8'h01; bus8.bin = 1'b0;
        @(posedge clk);
        #1 bus8.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus8.busy !== 1'b1) begin errors++; $display("FAIL b2b_no_idle: busy=%b, required 1", bus8.busy); end
        wait_done8(bc, ok);
        checks++;
        if (!ok || bc != 7 || bus8.diff !== 8'h7F || bus8.bout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: ok=%b busy_rest=%0d diff=%h bout=%b, required 1 7 7f 0", ok, bc, bus8.diff, bus8.bout);
        end
    endtask

    task automatic test_ignore_start();
        int dcount = 0;
        int first = 0;
        start8(8'h10, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (bus8.diff !== 8'h7F) begin errors++; $display("FAIL hold_in_run: diff=%h, required 7f", bus8.diff); end
        bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.bin = 1'b1;
        @(posedge clk);
        #1 bus8.start = 1'b0; bus8.a = 8'h33;
        for (int i = 4; i < 25; i++) begin
            @(negedge clk);
            if (bus8.done) begin
                dcount++;
                if (first == 0) first = i;
            end
        end
        checks++;
        if (dcount != 1 || first != 9) begin
            errors++;
            $display("FAIL ignore_pulses: %0d done pulses first at %0d, required 1 at 9", dcount, first);
        end
        checks++;
        if (bus8.diff !== 8'h0F || bus8.bout !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result: diff=%h bout=%b, required 0f 0", bus8.diff, bus8.bout);
        end
    endtask

    task automatic test_reset_mid_run();
        int dcount = 0;
        int bc;
        bit ok;
        start8(8'h20, 8'h10, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus8.busy, bus8.done, bus8.diff, bus8.bout} !== 11'd0) begin
            errors++;
            $display("FAIL rst_immediate: busy=%b done=%b diff=%h bout=%b, required all 0",
                     bus8.busy, bus8.done, bus8.diff, bus8.bout);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus8.busy, bus8.done, bus8.diff, bus8.bout} !== 11'd0) begin
                errors++;
                $display("FAIL rst_hold[%0d]: busy=%b done=%b diff=%h bout=%b, required all 0",
                         i, bus8.busy, bus8.done, bus8.diff, bus8.bout);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done) dcount++;
        end
        checks++;
        if (dcount != 0) begin errors++; $display("FAIL rst_no_done: %0d done pulses, required 0", dcount); end
        start8(8'h09, 8'h04, 1'b0);
        wait_done8(bc, ok);
        checks++;
        if (!ok || bc != 8 || bus8.diff !== 8'h05 || bus8.bout !== 1'b0) begin
            errors++;
            $display("FAIL rst_fresh: ok=%b busy=%0d diff=%h bout=%b, required 1 8 05 0", ok, bc, bus8.diff, bus8.bout);
        end
    endtask

    task automatic test_random8();
        logic [7:0] a, b, ed;
        logic       c, eb;
        int  bc;
        bit  ok;
        for (int n = 0; n < 1000; n++) begin
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom_range(0, 1));
            ed = 8'(ref_diff(longint'(a), longint'(b), longint'(c), 8));
            eb = ref_bout(longint'(a), longint'(b), longint'(c));
            start8(a, b, c);
            wait_done8(bc, ok);
            checks++;
            if (!ok || bus8.diff !== ed || bus8.bout !== eb) begin
                errors++;
                $display("FAIL rand8[%0d] %h-%h-%b: ok=%b diff=%h bout=%b, required diff=%h bout=%b",
                         n, a, b, c, ok, bus8.diff, bus8.bout, ed, eb);
            end
        end
    endtask

    task automatic test_random13();
        logic [12:0] a, b, ed;
        logic        c, eb;
        bit          ok;
        for (int n = 0; n < 1000; n++) begin
            a = 13'($urandom); b = 13'($urandom); c = 1'($urandom_range(0, 1));
            if (n % 50 == 0) b = a;
            ed = 13'(ref_diff(longint'(a), longint'(b), longint'(c), 13));
            eb = ref_bout(longint'(a), longint'(b), longint'(c));
            start13(a, b, c);
            wait_done13(ok);
            checks++;
            if (!ok || bus13.diff !== ed || bus13.bout !== eb) begin
                errors++;
                $display("FAIL rand13[%0d] %h-%h-%b: ok=%b diff=%h bout=%b, required diff=%h bout=%b",
                         n, a, b, c, ok, bus13.diff, bus13.bout, ed, eb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_run();
        test_random8();
        test_random13();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a subtraction; sampled on rising clk.
REQ-005 a  input  WIDTH  minuend, sampled when start is accepted.
REQ-006 b  input  WIDTH  subtrahend, sampled when start is accepted.
REQ-007 bin  input  1  borrow-in, sampled when start is accepted.
REQ-008 busy  output  1  high while an operation is in progress (state RUN).
REQ-009 done  output  1  one-cycle pulse, result registers just updated.
REQ-010 diff  output  WIDTH  registered result a - b - bin, modulo 2^WIDTH.
REQ-011 bout  output  1  registered borrow-out, 1 when a < b + bin (unsigned).

Function
REQ-012 Block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE: start=1 SHALL latch a, b, bin into internal shift registers and borrow flop, clear bit counter to 0, enter RUN.
REQ-014 RUN: each cycle SHALL process one bit, LSB first: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~a_i & br) | (b_i & br).
REQ-015 RUN: the result bit SHALL shift into the partial-difference register at MSB, operand registers shift right by one.
REQ-016 RUN: bit counter SHALL increment each cycle; after bit WIDTH-1 is processed, FSM SHALL enter DONE.
REQ-017 On the RUN->DONE edge, diff SHALL load the full partial-difference and bout SHALL load the final borrow.
REQ-018 DONE: done SHALL be 1 for exactly one cycle; busy SHALL be 0.
REQ-019 Latency: start accepted at edge E0 -> done high in the cycle following edge E(WIDTH); busy high from E0 to E(WIDTH).
REQ-020 diff/bout SHALL hold their last value from one done pulse to the next, including throughout RUN.
REQ-021 start while in RUN SHALL be ignored; a, b, bin changes during RUN SHALL not affect the result.
REQ-022 start=1 in DONE SHALL be accepted as in IDLE (back-to-back, next state RUN); otherwise DONE -> IDLE.
REQ-023 Counter width SHALL be clog2(WIDTH)+1; no wrap-around SHALL occur within an operation.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, busy=0, done=0, diff=0, bout=0, counter=0, shift registers=0.
REQ-025 rst asserted mid-RUN SHALL abort the operation with no done pulse; first start after release SHALL begin a fresh operation.
REQ-026 No output SHALL glitch to a non-reset value while rst=1.

Structure
REQ-027 FSM state encoding and WIDTH-derived counter width SHALL live in shared package sub_pkg.
REQ-028 The per-bit logic SHALL be a sub-module full_sub (inputs a, b, bin; outputs diff, bout), instantiated once.
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-030 WIDTH=8: a=0x05, b=0x03, bin=0, start 1 cycle -> busy 8 cycles, done pulse, diff=0x02, bout=0.
REQ-031 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-032 a=0xFF, b=0x00, bin=0 -> diff=0xFF, bout=0; then start again in DONE cycle with a=0x80, b=0x01 -> no IDLE cycle, diff=0x7F, bout=0.
REQ-033 Start 0x10-0x01; at cycle 3 of RUN pulse start with a=0xAA and change a/b -> ignored, diff=0x0F, single done pulse.
REQ-034 Start 0x20-0x10; assert rst at cycle 4 of RUN -> outputs 0 immediately, no done; after release start 0x09-0x04 -> diff=0x05, bout=0.
REQ-035 Random self-check, 1000 operations, WIDTH=8 and WIDTH=13: diff and bout SHALL match a - b - bin reference each done.
